// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: decode, memory handshakes,
// bus-timeout watchdog, optional muldiv wait, sticky trap, instret.
// Ports:
//   clk, rst (sync, active-high), instr, imem_ack, dmem_ack, md_done in.
//   imem_req, dmem_req, md_start, ir/pc/rf/ram write enables,
//   datapath selects (alu_op..ram_rb_op), trap, trap_cause, state, instret out.
module multicycle_control #(
  parameter bit ENABLE_MULDIV = 1'b0,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             md_done,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             md_start,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             ram_we,
  output logic [1:0]       rf_wsel,
  output logic [3:0]       alu_op,
  output logic             alua_sel,
  output logic             alub_sel,
  output logic [2:0]       sext_op,
  output logic [1:0]       npc_op,
  output logic             pc_sel,
  output logic [1:0]       ram_wdin_op,
  output logic [2:0]       ram_rb_op,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MDWAIT = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_t      st_q, st_d;
  logic [15:0] wait_cnt;
  logic [1:0]  cause_q, cause_d;
  logic        tmo_hit;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       op_r, md_op;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       is_lui, is_aui, is_jal, is_jalr, is_md;
  logic       illegal, dec_en;
  logic       unused_ok;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_ok = ^{instr[24:15], instr[11:7]};

  assign op_r    = (op == 7'b0110011);
  assign md_op   = op_r && (f7 == 7'b0000001);
  assign is_md   = md_op && ENABLE_MULDIV;
  assign is_r    = op_r && !md_op;
  assign is_i    = (op == 7'b0010011);
  assign is_ld   = (op == 7'b0000011);
  assign is_st   = (op == 7'b0100011);
  assign is_br   = (op == 7'b1100011);
  assign is_lui  = (op == 7'b0110111);
  assign is_aui  = (op == 7'b0010111);
  assign is_jal  = (op == 7'b1101111);
  assign is_jalr = (op == 7'b1100111);
  assign illegal = !(is_r | is_i | is_ld | is_st | is_br |
                     is_lui | is_aui | is_jal | is_jalr | is_md);

  // The IR is stale during FETCH, so selects sit at defaults there.
  assign dec_en = !rst && (st_q != ST_FETCH);

  function automatic logic [3:0] alu_f3(input logic [2:0] f,
                                        input logic alt);
    logic [3:0] r;
    r = 4'h0;
    case (f)
      3'b000: r = alt ? 4'h1 : 4'h0;
      3'b001: r = 4'h5;
      3'b010: r = 4'hA;
      3'b011: r = 4'hC;
      3'b100: r = 4'h4;
      3'b101: r = alt ? 4'h7 : 4'h6;
      3'b110: r = 4'h3;
      default: r = 4'h2;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_op      = 4'h0;
    alua_sel    = 1'b0;
    alub_sel    = 1'b0;
    sext_op     = 3'd0;
    rf_wsel     = 2'd0;
    npc_op      = 2'd0;
    pc_sel      = 1'b0;
    ram_wdin_op = 2'd2;
    ram_rb_op   = 3'd4;
    if (dec_en) begin
      unique case (1'b1)
        is_r: begin
          alu_op   = alu_f3(f3, f7[5]);
          alua_sel = 1'b1;
          alub_sel = 1'b1;
        end
        is_md: begin
          alua_sel = 1'b1;
          alub_sel = 1'b1;
        end
        is_i: begin
          // Only shifts use bit 30; addi immediates may set it.
          alu_op   = alu_f3(f3, (f3 == 3'b101) && f7[5]);
          alua_sel = 1'b1;
        end
        is_ld: begin
          alua_sel = 1'b1;
          rf_wsel  = 2'd1;
          case (f3)
            3'b000:  ram_rb_op = 3'd0;
            3'b100:  ram_rb_op = 3'd1;
            3'b001:  ram_rb_op = 3'd2;
            3'b101:  ram_rb_op = 3'd3;
            default: ram_rb_op = 3'd4;
          endcase
        end
        is_st: begin
          alua_sel = 1'b1;
          sext_op  = 3'd1;
          case (f3)
            3'b000:  ram_wdin_op = 2'd0;
            3'b001:  ram_wdin_op = 2'd1;
            default: ram_wdin_op = 2'd2;
          endcase
        end
        is_br: begin
          alua_sel = 1'b1;
          alub_sel = 1'b1;
          sext_op  = 3'd2;
          npc_op   = 2'd1;
          case (f3)
            3'b001:  alu_op = 4'h9;
            3'b100:  alu_op = 4'hA;
            3'b101:  alu_op = 4'hB;
            3'b110:  alu_op = 4'hC;
            3'b111:  alu_op = 4'hD;
            default: alu_op = 4'h8;
          endcase
        end
        is_lui: begin
          sext_op = 3'd3;
          rf_wsel = 2'd2;
        end
        is_aui: begin
          sext_op = 3'd3;
        end
        is_jal: begin
          sext_op = 3'd4;
          rf_wsel = 2'd3;
          npc_op  = 2'd2;
        end
        is_jalr: begin
          alua_sel = 1'b1;
          rf_wsel  = 2'd3;
          pc_sel   = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // An ack in the timeout cycle still wins.
  assign tmo_hit = ((wait_cnt + 16'd1) == TMO);

  always_comb begin
    st_d     = st_q;
    cause_d  = 2'd0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    md_start = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    ram_we   = 1'b0;
    unique case (st_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we = 1'b1;
          st_d  = ST_DECODE;
        end else if (tmo_hit) begin
          st_d    = ST_TRAP;
          cause_d = 2'd2;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          st_d    = ST_TRAP;
          cause_d = 2'd1;
        end else begin
          st_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unique case (1'b1)
          is_br: begin
            pc_we = 1'b1;
            st_d  = ST_FETCH;
          end
          is_ld, is_st: st_d = ST_MEM;
          is_md: begin
            md_start = 1'b1;
            st_d     = ST_MDWAIT;
          end
          default: st_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        ram_we   = is_st;
        if (dmem_ack) begin
          if (is_st) begin
            pc_we = 1'b1;
            st_d  = ST_FETCH;
          end else begin
            st_d = ST_WB;
          end
        end else if (tmo_hit) begin
          st_d    = ST_TRAP;
          cause_d = 2'd3;
        end
      end
      ST_MDWAIT: begin
        if (md_done) st_d = ST_WB;
      end
      ST_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        st_d  = ST_FETCH;
      end
      ST_TRAP: st_d = ST_TRAP;
      default: st_d = ST_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      md_start = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      ram_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_FETCH;
      wait_cnt <= 16'd0;
      cause_q  <= 2'd0;
      instret  <= '0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q)
        wait_cnt <= 16'd0;
      else if (imem_req || dmem_req)
        wait_cnt <= wait_cnt + 16'd1;
      if ((st_d == ST_TRAP) && (st_q != ST_TRAP))
        cause_q <= cause_d;
      if (pc_we)
        instret <= instret + CNT_W'(1);
    end
  end

  assign state      = st_q;
  assign trap       = (st_q == ST_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Per-cycle expected state/strobes/selects are queued, then compared.
module tb_multicycle_control;

  localparam int TMO = 4;

  localparam logic [6:0] S_IREQ  = 7'b1000000;
  localparam logic [6:0] S_DREQ  = 7'b0100000;
  localparam logic [6:0] S_MDS   = 7'b0010000;
  localparam logic [6:0] S_IRWE  = 7'b0001000;
  localparam logic [6:0] S_PCWE  = 7'b0000100;
  localparam logic [6:0] S_RFWE  = 7'b0000010;
  localparam logic [6:0] S_RAMWE = 7'b0000001;
  localparam logic [6:0] S_NONE  = 7'b0000000;

  localparam logic [2:0] SF = 3'd0;
  localparam logic [2:0] SD = 3'd1;
  localparam logic [2:0] SE = 3'd2;
  localparam logic [2:0] SM = 3'd3;
  localparam logic [2:0] SW = 3'd4;
  localparam logic [2:0] SX = 3'd5;
  localparam logic [2:0] ST = 3'd6;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        md_done = 1'b0;

  logic        imem_req, dmem_req, md_start;
  logic        ir_we, pc_we, rf_we, ram_we;
  logic [1:0]  rf_wsel, npc_op, ram_wdin_op, trap_cause;
  logic [3:0]  alu_op;
  logic        alua_sel, alub_sel, pc_sel, trap;
  logic [2:0]  sext_op, ram_rb_op, state;
  logic [3:0]  instret;

  logic        b_imem_req, b_dmem_req, b_md_start;
  logic        b_ir_we, b_pc_we, b_rf_we, b_ram_we;
  logic [1:0]  b_rf_wsel, b_npc_op, b_ram_wdin_op, b_trap_cause;
  logic [3:0]  b_alu_op;
  logic        b_alua_sel, b_alub_sel, b_pc_sel, b_trap;
  logic [2:0]  b_sext_op, b_ram_rb_op, b_state;
  logic [31:0] b_instret;

  always #5 clk = ~clk;

  multicycle_control #(
    .ENABLE_MULDIV(1'b1), .MEM_TIMEOUT(TMO), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .md_done(md_done),
    .imem_req(imem_req), .dmem_req(dmem_req), .md_start(md_start),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .ram_we(ram_we),
    .rf_wsel(rf_wsel), .alu_op(alu_op), .alua_sel(alua_sel),
    .alub_sel(alub_sel), .sext_op(sext_op), .npc_op(npc_op),
    .pc_sel(pc_sel), .ram_wdin_op(ram_wdin_op), .ram_rb_op(ram_rb_op),
    .trap(trap), .trap_cause(trap_cause), .state(state),
    .instret(instret)
  );

  multicycle_control dut_b (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .md_done(md_done),
    .imem_req(b_imem_req), .dmem_req(b_dmem_req),
    .md_start(b_md_start), .ir_we(b_ir_we), .pc_we(b_pc_we),
    .rf_we(b_rf_we), .ram_we(b_ram_we), .rf_wsel(b_rf_wsel),
    .alu_op(b_alu_op), .alua_sel(b_alua_sel), .alub_sel(b_alub_sel),
    .sext_op(b_sext_op), .npc_op(b_npc_op), .pc_sel(b_pc_sel),
    .ram_wdin_op(b_ram_wdin_op), .ram_rb_op(b_ram_rb_op),
    .trap(b_trap), .trap_cause(b_trap_cause), .state(b_state),
    .instret(b_instret)
  );

  logic [6:0]  stb_o;
  logic [18:0] sel_o;
  assign stb_o = {imem_req, dmem_req, md_start, ir_we,
                  pc_we, rf_we, ram_we};
  assign sel_o = {alu_op, alua_sel, alub_sel, sext_op, rf_wsel,
                  npc_op, pc_sel, ram_wdin_op, ram_rb_op};

  typedef struct {
    logic [2:0]  st;
    logic [6:0]  stb;
    logic        ia;
    logic        da;
    logic        md;
    logic        cs;
    logic [18:0] sel;
  } cyc_t;

  cyc_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_ret = 0;

  logic [18:0] DEF, SEL_ADDI, SEL_BEQ, SEL_LW, SEL_SB, SEL_SW;
  logic [18:0] SEL_MUL, SEL_JAL, SEL_SUB;

  function automatic logic [18:0] mk_sel(
    input logic [3:0] alu, input logic a, input logic b,
    input logic [2:0] sx, input logic [1:0] rf, input logic [1:0] np,
    input logic ps, input logic [1:0] wd, input logic [2:0] rb);
    return {alu, a, b, sx, rf, np, ps, wd, rb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [2:0] st, input logic [6:0] stb,
                     input logic ia, input logic da, input logic md,
                     input logic cs, input logic [18:0] sel);
    cyc_t e;
    e.st = st; e.stb = stb; e.ia = ia; e.da = da;
    e.md = md; e.cs = cs; e.sel = sel;
    q.push_back(e);
  endtask

  // Entered and left at a falling edge.
  task automatic run(input string nm, input logic [31:0] ins,
                     input int iw, input int dw, input int mw,
                     input logic [18:0] sel);
    logic [6:0] op;
    logic       is_md, is_br, is_ld, is_st, ill;
    logic       tr, ret;
    logic [1:0] cs;
    logic [6:0] w;
    cyc_t       e;
    int         cyc;
    op    = ins[6:0];
    is_md = (op == 7'b0110011) && (ins[31:25] == 7'b0000001);
    is_br = (op == 7'b1100011);
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    ill   = !(op inside {7'b0110011, 7'b0010011, 7'b0000011,
                         7'b0100011, 7'b1100011, 7'b0110111,
                         7'b0010111, 7'b1101111, 7'b1100111});
    tr = L; ret = L; cs = 2'd0;
    instr = ins;
    for (int i = 0; i < iw && i < TMO; i++)
      put(SF, S_IREQ, L, H, H, H, DEF);
    if (iw >= TMO) begin
      tr = H; cs = 2'd2;
    end else begin
      put(SF, S_IREQ | S_IRWE, H, H, H, H, DEF);
      put(SD, S_NONE, H, H, H, H, sel);
      if (ill) begin
        tr = H; cs = 2'd1;
      end else if (is_br) begin
        put(SE, S_PCWE, H, H, H, H, sel);
        ret = H;
      end else if (is_md) begin
        put(SE, S_MDS, H, H, H, H, sel);
        for (int i = 0; i < mw; i++)
          put(SX, S_NONE, H, H, L, H, sel);
        put(SX, S_NONE, H, H, H, H, sel);
        put(SW, S_RFWE | S_PCWE, H, H, H, H, sel);
        ret = H;
      end else if (is_ld || is_st) begin
        put(SE, S_NONE, H, H, H, H, sel);
        w = is_st ? (S_DREQ | S_RAMWE) : S_DREQ;
        for (int i = 0; i < dw && i < TMO; i++)
          put(SM, w, H, L, H, H, sel);
        if (dw >= TMO) begin
          tr = H; cs = 2'd3;
        end else begin
          put(SM, w | (is_st ? S_PCWE : S_NONE), H, H, H, H, sel);
          if (is_ld) put(SW, S_RFWE | S_PCWE, H, H, H, H, sel);
          ret = H;
        end
      end else begin
        put(SE, S_NONE, H, H, H, H, sel);
        put(SW, S_RFWE | S_PCWE, H, H, H, H, sel);
        ret = H;
      end
    end
    if (tr)
      for (int i = 0; i < 3; i++)
        put(ST, S_NONE, H, H, H, L, sel);
    if (ret) exp_ret++;
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      imem_ack = e.ia;
      dmem_ack = e.da;
      md_done  = e.md;
      #1;
      chk($sformatf("%s:st%0d", nm, cyc), 32'(state), 32'(e.st));
      chk($sformatf("%s:stb%0d", nm, cyc), 32'(stb_o), 32'(e.stb));
      if (e.cs)
        chk($sformatf("%s:sel%0d", nm, cyc), 32'(sel_o), 32'(e.sel));
      cyc++;
      @(negedge clk);
    end
    chk({nm, ":instret"}, 32'(instret), 32'(exp_ret % 16));
    chk({nm, ":trap"}, 32'(trap), 32'(tr));
    chk({nm, ":cause"}, 32'(trap_cause), 32'(cs));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b1; dmem_ack = 1'b1; md_done = 1'b1;
    #1;
    chk("rst_stb_now", 32'(stb_o), 32'(S_NONE));
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(SF));
    chk("rst_stb", 32'(stb_o), 32'(S_NONE));
    chk("rst_sel", 32'(sel_o), 32'(DEF));
    chk("rst_trap", 32'({trap, trap_cause}), 32'(0));
    chk("rst_instret", 32'(instret), 32'(0));
    chk("rst_b", 32'({b_state, b_trap, b_instret == 0}), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; md_done = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    DEF      = mk_sel(4'h0, L, L, 3'd0, 2'd0, 2'd0, L, 2'd2, 3'd4);
    SEL_ADDI = mk_sel(4'h0, H, L, 3'd0, 2'd0, 2'd0, L, 2'd2, 3'd4);
    SEL_BEQ  = mk_sel(4'h8, H, H, 3'd2, 2'd0, 2'd1, L, 2'd2, 3'd4);
    SEL_LW   = mk_sel(4'h0, H, L, 3'd0, 2'd1, 2'd0, L, 2'd2, 3'd4);
    SEL_SB   = mk_sel(4'h0, H, L, 3'd1, 2'd0, 2'd0, L, 2'd0, 3'd4);
    SEL_SW   = mk_sel(4'h0, H, L, 3'd1, 2'd0, 2'd0, L, 2'd2, 3'd4);
    SEL_MUL  = mk_sel(4'h0, H, H, 3'd0, 2'd0, 2'd0, L, 2'd2, 3'd4);
    SEL_JAL  = mk_sel(4'h0, L, L, 3'd4, 2'd3, 2'd2, L, 2'd2, 3'd4);
    SEL_SUB  = mk_sel(4'h1, H, H, 3'd0, 2'd0, 2'd0, L, 2'd2, 3'd4);

    @(negedge clk);
    do_reset();
    run("addi", 32'h00500093, 2, 0, 0, SEL_ADDI);
    run("beq",  32'h00000463, 0, 0, 0, SEL_BEQ);
    run("lw",   32'h0000a103, 0, 3, 0, SEL_LW);
    run("sb",   32'h00208023, 1, 0, 0, SEL_SB);
    run("jal",  32'h008000ef, 0, 0, 0, SEL_JAL);
    run("sub",  32'h402081b3, 0, 0, 0, SEL_SUB);
    chk("b_sync_ret", b_instret, 32'd6);
    chk("b_sync_st", 32'(b_state), 32'(SF));
    run("mul",  32'h02208033, 0, 0, 2, SEL_MUL);
    chk("b_mul_trap", 32'({b_state, b_trap, b_trap_cause}),
        32'({ST, H, 2'd1}));
    chk("b_mul_ret", b_instret, 32'd6);
    do_reset();
    run("ill",  32'hffffffff, 0, 0, 0, DEF);
    do_reset();
    run("ito",  32'h00500093, 4, 0, 0, SEL_ADDI);
    do_reset();
    run("iok",  32'h00500093, 3, 0, 0, SEL_ADDI);
    run("dto",  32'h0000a103, 0, 4, 0, SEL_LW);
    do_reset();
    run("sw",   32'h0020a023, 0, 3, 0, SEL_SW);

    instr = 32'h0000a103;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_mem", 32'({state, stb_o}), 32'({SM, S_DREQ}));
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 17; i++)
      run($sformatf("wrap%0d", i), 32'h00500093, 0, 0, 0, SEL_ADDI);
    chk("wrap_b_ret", b_instret, 32'd17);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle RV32I control unit: same decode and control-signal encodings, but sequenced by an FSM over FETCH/DECODE/EXEC/MEM/WB so instruction and data memories may take a variable number of cycles. It adds three things the single-cycle unit lacks:
- memory request/acknowledge handshakes with a bus-timeout watchdog;
- an optional multiply/divide wait state;
- a sticky trap state and a retired-instruction counter.

It sits between the instruction register, the datapath muxes/ALU and the memory interfaces of the multi-cycle core.

## Interface
Parameters:
- ENABLE_MULDIV, 0: 1 decodes RV32M (opcode 0110011, funct7 0000001) to the MDWAIT path; 0 treats it as illegal.
- MEM_TIMEOUT, 255: maximum cycles to wait for an ack. Valid range 1..65535.
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- instr  in  32  instruction register contents, valid from DECODE onward.
- imem_ack  in  1  instruction fetch complete. Instruction is written to the IR on the same edge.
- dmem_ack  in  1  data access complete.
- md_done  in  1  multiply/divide result valid.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- md_start  out  1  one-cycle multiply/divide start pulse.
- ir_we, pc_we, rf_we, ram_we  out  1 each  register and memory write enables.
- rf_wsel  out  2  writeback source: 0 ALU, 1 RAM, 2 ext, 3 PC+4. Muldiv writeback uses 0; the datapath muxes the md result on that selection.
- alu_op  out  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 eq, 9 ne, A lt, B ge, C ltu, D geu.
- alua_sel  out  1  ALU operand A: 0 PC, 1 rs1.
- alub_sel  out  1  ALU operand B: 0 imm, 1 rs2.
- sext_op  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J.
- npc_op  out  2  next PC: 0 PC+4, 1 branch, 2 JAL.
- pc_sel  out  1  1 selects rs1+imm (JALR).
- ram_wdin_op  out  2  store width: 0 sb, 1 sh, 2 sw.
- ram_rb_op  out  3  load type: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout.
- state  out  3  current FSM state, for debug.
- instret  out  CNT_W  retired instruction count.

## Operation
States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, TRAP=6.

Datapath selects (alu_op, alua_sel, alub_sel, sext_op, rf_wsel, npc_op, pc_sel, ram_wdin_op, ram_rb_op) are decoded combinationally from instr with single-cycle semantics and are valid in every state after FETCH.

Strobes (ir_we, pc_we, rf_we, ram_we, *_req, md_start) are gated by state:
- FETCH: imem_req=1 until imem_ack. On ack: ir_we=1, go to DECODE.
- DECODE: one cycle. Unknown opcode, or RV32M with ENABLE_MULDIV=0, goes to TRAP with cause 1. Otherwise go to EXEC.
- EXEC: one cycle. Next state by instruction:
  - R/I/LUI/AUIPC/JAL/JALR: go to WB.
  - Load/store: go to MEM.
  - Branch: pc_we=1 with npc_op=1, go to FETCH.
  - RV32M: md_start=1, go to MDWAIT.
- MEM: dmem_req=1; ram_we=1 for stores, held until ack. On ack:
  - load: go to WB;
  - store: pc_we=1, go to FETCH.
- MDWAIT: wait for md_done, then go to WB.
- WB: rf_we=1 and pc_we=1 for one cycle, go to FETCH.
- TRAP: all strobes 0, stays in TRAP until rst. trap=1, trap_cause held.

Invariants:
- pc_we is asserted exactly once per retired instruction.
- instret increments on that same cycle and wraps modulo 2^CNT_W.
- x0 protection is the register file's job, not this block's.

Watchdog:
- A 16-bit wait counter clears on entry to FETCH or MEM and increments on every cycle without an ack.
- When the counter reaches MEM_TIMEOUT with no ack, the FSM goes to TRAP with cause 2 (FETCH) or 3 (MEM).
- An ack arriving in the same cycle as the timeout wins: no trap.

## Timing
- Reset value of every output is 0, except: state=FETCH, alu_op=add (the default decode), ram_wdin_op=2, ram_rb_op=4. instret=0, trap=0.
- rst asserted mid-instruction aborts the instruction. Next cycle is FETCH with no strobes asserted.
- Latency, with an ack in the first request cycle:
  - ALU/jump instructions: 4 cycles;
  - branch: 3 cycles;
  - load: 5 cycles;
  - store: 4 cycles;
  - muldiv: 4 cycles plus the md_done wait.
- imem_ack/dmem_ack are ignored outside FETCH/MEM respectively. md_done is ignored outside MDWAIT.

## Test plan
- addi x1,x0,5 (0x00500093), imem_ack after 2 wait cycles → states 0,0,0,1,2,4,0; rf_we and pc_we high only in WB; instret=1.
- beq taken (0x00000463) → EXEC has alu_op=8, npc_op=1, pc_we=1; rf_we never asserted; returns to FETCH after 3 cycles from ack.
- lw (0x0000a103) with dmem_ack held low 3 cycles → dmem_req high 4 cycles, ram_rb_op=4, then WB with rf_wsel=1. sb (0x00208023) → ram_we=1, ram_wdin_op=0 during MEM, pc_we on ack.
- ENABLE_MULDIV=1, mul (0x02208033) → md_start one pulse, MDWAIT until md_done, then WB. With ENABLE_MULDIV=0 → TRAP, trap_cause=1.
- MEM_TIMEOUT=4, imem_ack never asserted → TRAP after 4 wait cycles, cause 2, outputs stay frozen. Second run: ack on the 4th cycle → no trap. rst in TRAP → FETCH, trap=0.
- Retire 2^CNT_W instructions with CNT_W=4 → instret wraps 15→0.
